store_narrow_rmw: RTL and testbench
===================================

# store_narrow_rmw

Store-side narrowing unit for the unpipelined 16-bit datapath; it is the write-direction counterpart of the load-side 5/8→16 sign/zero extenders. It takes a 16-bit register value, narrows it to a byte with a signed or unsigned range check, and commits it to word-organised data memory. Word stores are single writes; byte stores use a read-modify-write sequence driven by a small FSM.

## Interface
Parameters
- `ADDR_W`, default 16: byte-address width.

Ports
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_data`  in  16  register value to store.
- `req_size`  in  1  0 = byte store, 1 = word store.
- `req_sign`  in  1  1 = signed range check, 0 = unsigned range check (byte stores only).
- `mem_rd_en`  out  1  memory read strobe; held until `mem_ready`.
- `mem_wr_en`  out  1  memory write strobe; held until `mem_ready`.
- `mem_addr`  out  `ADDR_W`  word address: `req_addr` with bit 0 forced to 0.
- `mem_wdata`  out  16  write data.
- `mem_rdata`  in  16  read data; valid when `mem_rd_en && mem_ready`.
- `mem_ready`  in  1  memory completes the current strobe this cycle.
- `done`  out  1  one-cycle pulse when the store has completed.
- `ovf`  out  1  narrowing overflow for the completed store; valid while `done` is high.

## Operation
- States: IDLE, RD, WR, DONE.
  - IDLE: `req_ready`=1. A request is accepted when `req_valid && req_ready`. Accepting latches addr, data, size and sign. Go to WR if `req_size`=1, otherwise to RD.
  - RD: `mem_rd_en`=1. On `mem_ready`, latch the merged word and go to WR.
  - WR: `mem_wr_en`=1. On `mem_ready`, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Byte lanes are little-endian. `addr[0]`=0 replaces `rdata[7:0]`; `addr[0]`=1 replaces `rdata[15:8]`. The other byte is preserved unchanged.
- Range check (byte stores only):
  - signed fit ⇔ `data[15:7]` are all equal;
  - unsigned fit ⇔ `data[15:8]`==0;
  - `ovf` = !fit.
  - Word stores always give `ovf`=0 and write `req_data` unchanged.
- The narrowed byte is `data[7:0]` unless `STORE_NARROW_SAT_EN` is defined (see Configuration).
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- All strobes and `mem_addr`/`mem_wdata` come only from registered state. There is no combinational path from `req_*` to `mem_*`.
- `mem_addr` and `mem_wdata` are stable for the whole time a strobe is asserted.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `ovf`=0.
- Word store with `mem_ready` tied high: accept at edge 0; WR in cycle 1; `done` in cycle 2. Latency is 2 cycles.
- Byte store with `mem_ready` tied high: RD in cycle 1, WR in cycle 2, `done` in cycle 3. Latency is 3 cycles.
- Each cycle with `mem_ready`=0 adds one cycle in the current state.
- `req_ready` goes low the cycle after acceptance. Requests presented while busy are ignored; the requester holds them.
- A new request can be accepted at the first IDLE cycle after DONE. The minimum spacing between acceptances is latency+1 cycles.
- `ovf` holds its value from DONE until the next DONE; it is cleared only by `rst`.
- Reset mid-operation: on the next edge the unit returns to IDLE and all strobes drop. No partial write is counted as done, and `done` is not pulsed.
- Reset has priority over acceptance when `rst` and `req_valid` are high together.

## Configuration
- `STORE_NARROW_SAT_EN` defined: an out-of-range byte saturates.
  - Signed: positive values → 0x7F, negative values → 0x80.
  - Unsigned: → 0xFF.
  - `ovf` is still reported.
- `STORE_NARROW_SAT_EN` undefined: the byte is always `data[7:0]` (truncation) and `ovf` is reported.
- Word stores behave identically in both builds.

## Test plan
- Word store, `mem_ready`=1: addr=0x0010, data=0xBEEF → write 0xBEEF to 0x0010 in cycle 1; `done` in cycle 2; `ovf`=0.
- Byte store, signed, low lane: memory 0x1234 at 0x0020; addr=0x0020, data=0xFFF0 → read, then write 0x12F0; `ovf`=0; `done` in cycle 3.
- Byte store, unsigned, high lane, overflow: memory 0x1234 at 0x0020; addr=0x0021, data=0x0150.
  - Without macro → write 0x5034, `ovf`=1.
  - With `STORE_NARROW_SAT_EN` → write 0xFF34, `ovf`=1.
- Signed negative saturation with `STORE_NARROW_SAT_EN`: addr=0x0020, data=0xFF00, memory 0x1234 → write 0x1280, `ovf`=1.
- Stall: `mem_ready` held 0 for 3 cycles during RD. Required: `mem_rd_en` and `mem_addr` stay steady, `req_ready`=0, no write occurs, `done` occurs 3 cycles late.
- Reset in WR with `mem_ready`=0: all outputs return to reset values on the next edge, `done` is never pulsed, and a new request is accepted in the following cycle.

Source files
------------

// File: rtl/store_narrow_rmw.sv
//==============================================================================
// Module  : store_narrow_rmw
// Purpose : Narrows a 16-bit register value to a byte with range check and
//           commits it to word memory (word write or byte read-modify-write).
//           Optional macro STORE_NARROW_SAT_EN saturates out-of-range bytes.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module store_narrow_rmw #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_data,
    input  logic              req_size,
    input  logic              req_sign,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic [15:0]       r_wdata;
    logic              r_size;
    logic              r_sign;
    logic              r_ovf;

    logic              w_accept;
    logic              w_fit;
    logic [7:0]        w_byte;
    logic [15:0]       w_merged;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Signed fit: bits 15..7 all identical; unsigned fit: upper byte zero.
    assign w_fit = r_sign ? ((&r_data[15:7]) | ~(|r_data[15:7]))
                          : ~(|r_data[15:8]);

`ifdef STORE_NARROW_SAT_EN
    localparam logic [7:0] c_sat_spos = 8'h7F;
    localparam logic [7:0] c_sat_sneg = 8'h80;
    localparam logic [7:0] c_sat_umax = 8'hFF;

    always_comb begin
        w_byte = r_data[7:0];
        if (!w_fit) begin
            if (r_sign) w_byte = r_data[15] ? c_sat_sneg : c_sat_spos;
            else        w_byte = c_sat_umax;
        end
    end
`else
    assign w_byte = r_data[7:0];
`endif

    // Little-endian lane select; the untouched byte comes from the read word.
    assign w_merged = r_addr[0] ? {w_byte, mem_rdata[7:0]}
                                : {mem_rdata[15:8], w_byte};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req_valid) w_next = req_size ? S_WR : S_RD;
            S_RD:   if (mem_ready) w_next = S_WR;
            S_WR:   if (mem_ready) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_wdata <= '0;
            r_size  <= 1'b0;
            r_sign  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_data  <= req_data;
                r_wdata <= req_data;
                r_size  <= req_size;
                r_sign  <= req_sign;
            end
            if (r_state == S_RD && mem_ready) r_wdata <= w_merged;
            if (r_state == S_WR && mem_ready) r_ovf <= ~r_size & ~w_fit;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign mem_rd_en = (r_state == S_RD);
    assign mem_wr_en = (r_state == S_WR);
    assign mem_addr  = {r_addr[ADDR_W-1:1], 1'b0};
    assign mem_wdata = r_wdata;
    assign done      = (r_state == S_DONE);
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_store_narrow_rmw.sv
//==============================================================================
// Module  : tb_store_narrow_rmw
// Purpose : Self-checking bench for store_narrow_rmw against a word-memory model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_store_narrow_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        req_size;
    logic        req_sign;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        done;
    logic        ovf;

    logic [15:0] tbmem [0:255];
    logic        last_ovf;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    store_narrow_rmw #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .req_size(req_size), .req_sign(req_sign),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .done(done), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the byte to store and whether the value fits its range.
    function automatic logic [8:0] narrow(input logic [15:0] d, input logic sg);
        int         v;
        logic       fit;
        logic [7:0] b;
        v   = sg ? int'($signed(d)) : int'(d);
        fit = sg ? (v >= -128 && v <= 127) : (v <= 255);
        b   = d[7:0];
`ifdef STORE_NARROW_SAT_EN
        if (!fit) b = sg ? ((v < 0) ? 8'h80 : 8'h7F) : 8'hFF;
`endif
        return {~fit, b};
    endfunction

    // Caller is at a negedge with the unit idle; returns at the negedge of the done cycle.
    task automatic do_store(input logic [15:0] a, input logic [15:0] d,
                            input logic sz, input logic sg, input int srd, input int swr);
        logic [15:0] old, exp_word;
        logic [8:0]  nb;
        logic        exp_ovf;
        int          nrd, nwr, total, sh;
        logic        is_rd, is_wr, is_done;
        old = tbmem[a[8:1]];
        if (sz) begin
            exp_word = d;
            exp_ovf  = 1'b0;
        end else begin
            nb       = narrow(d, sg);
            sh       = a[0] ? 8 : 0;
            exp_word = (old & ~(16'h00FF << sh)) | (16'(nb[7:0]) << sh);
            exp_ovf  = nb[8];
        end
        nrd   = sz ? 0 : 1 + srd;
        nwr   = 1 + swr;
        total = nrd + nwr + 1;

        chk("idle_ready", 16'(req_ready), 16'd1);
        chk("idle_ovf_hold", 16'(ovf), 16'(last_ovf));
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz; req_sign = sg;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            is_rd   = (k <= nrd);
            is_wr   = (k > nrd) && (k <= nrd + nwr);
            is_done = (k == total);
            chk("rd_en", 16'(mem_rd_en), 16'(is_rd));
            chk("wr_en", 16'(mem_wr_en), 16'(is_wr));
            chk("done", 16'(done), 16'(is_done));
            chk("busy_ready", 16'(req_ready), 16'd0);
            if (is_rd || is_wr) chk("mem_addr", mem_addr, {a[15:1], 1'b0});
            if (is_wr) chk("mem_wdata", mem_wdata, exp_word);
            if (is_done) chk("ovf", 16'(ovf), 16'(exp_ovf));
            mem_rdata = 16'($urandom);
            if (is_rd) begin
                mem_ready = (k == nrd);
                mem_rdata = old;
            end else if (is_wr) begin
                mem_ready = (k == nrd + nwr);
                if (mem_ready) tbmem[a[8:1]] = exp_word;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            // Busy-time requests must be ignored.
            req_valid = is_done ? 1'b0 : 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_data  = 16'($urandom);
            req_size  = 1'($urandom_range(0, 1));
            req_sign  = 1'($urandom_range(0, 1));
        end
        last_ovf = exp_ovf;
    endtask

    initial begin
        logic [15:0] ra, rd;
        for (int i = 0; i < 256; i++) tbmem[i] = 16'($urandom);
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_size = 1'b0; req_sign = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        last_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 16'(req_ready), 16'd1);
        chk("rst_rd_en", 16'(mem_rd_en), 16'd0);
        chk("rst_wr_en", 16'(mem_wr_en), 16'd0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_ovf", 16'(ovf), 16'd0);
        rst = 1'b0;

        do_store(16'h0010, 16'hBEEF, 1'b1, 1'b0, 0, 0);
        chk("word_mem", tbmem[8], 16'hBEEF);
        @(negedge clk);
        tbmem[16] = 16'h1234;
        do_store(16'h0020, 16'hFFF0, 1'b0, 1'b1, 0, 0);
        chk("byte_lo_mem", tbmem[16], 16'h12F0);
        @(negedge clk);
        tbmem[16] = 16'h1234;
        do_store(16'h0021, 16'h0150, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        tbmem[16] = 16'h1234;
        do_store(16'h0020, 16'hFF00, 1'b0, 1'b1, 0, 0);
        @(negedge clk);
        do_store(16'h0033, 16'h007F, 1'b0, 1'b1, 3, 0);
        @(negedge clk);
        do_store(16'h0044, 16'h0180, 1'b0, 1'b1, 1, 2);

        // Reset while a write is stalled; ovf from the last store is 1.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 16'h0040; req_data = 16'hAAAA;
        req_size = 1'b1; req_sign = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstwr_wr_en", 16'(mem_wr_en), 16'd1);
        rst = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstwr_ready", 16'(req_ready), 16'd1);
        chk("rstwr_wr_en0", 16'(mem_wr_en), 16'd0);
        chk("rstwr_rd_en0", 16'(mem_rd_en), 16'd0);
        chk("rstwr_addr", mem_addr, 16'h0000);
        chk("rstwr_wdata", mem_wdata, 16'h0000);
        chk("rstwr_done", 16'(done), 16'd0);
        chk("rstwr_ovf", 16'(ovf), 16'd0);
        rst = 1'b0; last_ovf = 1'b0;
        do_store(16'h0050, 16'h1357, 1'b0, 1'b0, 0, 1);

        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            ra = 16'($urandom_range(0, 511));
            case ($urandom_range(0, 3))
                0: rd = 16'($urandom);
                1: rd = 16'($urandom_range(0, 511));
                2: rd = 16'hFF00 | 16'($urandom_range(0, 255));
                default: rd = 16'(16'h007E + $urandom_range(0, 3)) ^ (($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000);
            endcase
            do_store(ra, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end
        @(negedge clk);
        chk("final_ready", 16'(req_ready), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
